// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameters for the run controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int DEF_D       = 12;
  localparam int DEF_RST_CYC = 2;
  localparam int DEF_CW      = 16;
  localparam int DEF_MAX_CYC = 4095;

endpackage

// File: rtl/sat_counter.sv
// W-bit up-counter that sticks at all-ones; synchronous reset and clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Sequences the core through reset, run and freeze on a four-phase
// req/done handshake; counts run cycles and captures the final PC.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int D       = DEF_D,
  parameter int RST_CYC = DEF_RST_CYC,
  parameter int CW      = DEF_CW,
  parameter int MAX_CYC = DEF_MAX_CYC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          core_done,
  input  logic [D-1:0]  pc,
  output logic          core_reset,
  output logic          busy,
  output logic          done,
  output logic          timed_out,
  output logic [CW-1:0] cycles,
  output logic [D-1:0]  end_pc
);

  localparam int              CLR_W    = $clog2(RST_CYC + 1);
  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(RST_CYC - 1);
  localparam logic [CW-1:0]    LAST_CYC = CW'(MAX_CYC - 1);

  state_t           state;
  logic [CLR_W-1:0] clr_cnt;
  logic             cnt_clear;
  logic             cnt_en;
  logic             run_end;

  // Every cycle spent in RUN is counted, including the one that exits.
  assign cnt_clear = (state == ST_IDLE) && req;
  assign cnt_en    = (state == ST_RUN);
  assign run_end   = core_done || (cycles == LAST_CYC);

  sat_counter #(.W(CW)) u_cycles (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .count (cycles)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      clr_cnt    <= '0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      timed_out  <= 1'b0;
      end_pc     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state     <= ST_CLEAR;
            clr_cnt   <= CLR_LOAD;
            busy      <= 1'b1;
            timed_out <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (!req) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (clr_cnt == '0) begin
            state      <= ST_RUN;
            core_reset <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt - 1'b1;
          end
        end
        ST_RUN: begin
          if (!req) begin
            state      <= ST_IDLE;
            core_reset <= 1'b1;
            busy       <= 1'b0;
          end else if (run_end) begin
            // core_done outranks a coincident timeout.
            state      <= ST_FINISH;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
            timed_out  <= !core_done;
            end_pc     <= pc;
          end
        end
        ST_FINISH: begin
          if (!req) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Two run_ctrl instances (long and short timeout) on shared stimulus,
// checked every cycle against a behavioural model plus directed spot checks.
module tb_run_ctrl;

  localparam int D      = 12;
  localparam int CW     = 16;
  localparam int RST    = 2;
  localparam int MAX_A  = 4095;
  localparam int MAX_B  = 20;
  localparam int SAT    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic          core_done = 1'b0;
  logic [D-1:0]  pc = '0;

  logic          core_reset_a, busy_a, done_a, timed_out_a;
  logic [CW-1:0] cycles_a;
  logic [D-1:0]  end_pc_a;
  logic          core_reset_b, busy_b, done_b, timed_out_b;
  logic [CW-1:0] cycles_b;
  logic [D-1:0]  end_pc_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  run_ctrl #(.D(D), .RST_CYC(RST), .CW(CW), .MAX_CYC(MAX_A)) dut_a (
    .clk(clk), .reset(reset), .req(req), .core_done(core_done), .pc(pc),
    .core_reset(core_reset_a), .busy(busy_a), .done(done_a),
    .timed_out(timed_out_a), .cycles(cycles_a), .end_pc(end_pc_a)
  );

  run_ctrl #(.D(D), .RST_CYC(RST), .CW(CW), .MAX_CYC(MAX_B)) dut_b (
    .clk(clk), .reset(reset), .req(req), .core_done(core_done), .pc(pc),
    .core_reset(core_reset_b), .busy(busy_b), .done(done_b),
    .timed_out(timed_out_b), .cycles(cycles_b), .end_pc(end_pc_b)
  );

  // Behavioural model: phase 0 idle, 1 clearing, 2 running, 3 finished.
  typedef struct {
    int phase;
    int clr_left;
    int cyc;
    bit tout;
    int epc;
    bit crst;
    bit busy;
    bit done;
  } model_t;

  model_t ma, mb;

  function automatic model_t reset_model();
    model_t m;
    m.phase = 0; m.clr_left = 0; m.cyc = 0; m.tout = 0;
    m.epc = 0; m.crst = 1; m.busy = 0; m.done = 0;
    return m;
  endfunction

  function automatic model_t step(model_t m, int max_cyc, bit rst, bit rq,
                                  bit cd, int p);
    if (rst) return reset_model();
    case (m.phase)
      0: if (rq) begin
        m.phase = 1; m.clr_left = RST; m.cyc = 0; m.tout = 0; m.busy = 1;
      end
      1: if (!rq) begin
        m.phase = 0; m.busy = 0;
      end else begin
        m.clr_left--;
        if (m.clr_left == 0) begin
          m.phase = 2; m.crst = 0;
        end
      end
      2: begin
        m.cyc = (m.cyc < SAT) ? m.cyc + 1 : SAT;
        if (!rq) begin
          m.phase = 0; m.crst = 1; m.busy = 0;
        end else if (cd || m.cyc == max_cyc) begin
          m.phase = 3; m.crst = 1; m.busy = 0; m.done = 1;
          m.tout = !cd; m.epc = p;
        end
      end
      default: if (!rq) begin
        m.phase = 0; m.done = 0;
      end
    endcase
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("a.core_reset", 32'(core_reset_a), 32'(ma.crst));
    check("a.busy",       32'(busy_a),       32'(ma.busy));
    check("a.done",       32'(done_a),       32'(ma.done));
    check("a.timed_out",  32'(timed_out_a),  32'(ma.tout));
    check("a.cycles",     32'(cycles_a),     32'(ma.cyc));
    check("a.end_pc",     32'(end_pc_a),     32'(ma.epc));
    check("b.core_reset", 32'(core_reset_b), 32'(mb.crst));
    check("b.busy",       32'(busy_b),       32'(mb.busy));
    check("b.done",       32'(done_b),       32'(mb.done));
    check("b.timed_out",  32'(timed_out_b),  32'(mb.tout));
    check("b.cycles",     32'(cycles_b),     32'(mb.cyc));
    check("b.end_pc",     32'(end_pc_b),     32'(mb.epc));
  endtask

  // Inputs are changed only between ticks (at the falling edge).
  task automatic tick();
    @(posedge clk);
    ma = step(ma, MAX_A, reset, req, core_done, int'(pc));
    mb = step(mb, MAX_B, reset, req, core_done, int'(pc));
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pc = D'($urandom);
      tick();
    end
  endtask

  initial begin
    int lat;
    ma = reset_model();
    mb = reset_model();

    // Reset
    reset = 1'b1;
    ticks(2);
    check("rst.core_reset", 32'(core_reset_a), 32'd1);
    check("rst.busy",       32'(busy_a),       32'd0);
    check("rst.done",       32'(done_a),       32'd0);
    check("rst.cycles",     32'(cycles_a),     32'd0);
    check("rst.end_pc",     32'(end_pc_a),     32'd0);
    reset = 1'b0;
    ticks(2);

    // Normal run: 40 RUN cycles on A; B times out at 20 meanwhile
    req = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (core_reset_a && lat < 10);
    check("start.latency", 32'(lat), 32'(RST + 1));
    check("start.busy", 32'(busy_a), 32'd1);
    ticks(39);
    pc = 12'd128;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("run.done",       32'(done_a),       32'd1);
    check("run.timed_out",  32'(timed_out_a),  32'd0);
    check("run.cycles",     32'(cycles_a),     32'd40);
    check("run.end_pc",     32'(end_pc_a),     32'd128);
    check("run.core_reset", 32'(core_reset_a), 32'd1);
    check("tout.done",      32'(done_b),       32'd1);
    check("tout.timed_out", 32'(timed_out_b),  32'd1);
    check("tout.cycles",    32'(cycles_b),     32'd20);
    req = 1'b0;
    tick();
    check("release.done", 32'(done_a), 32'd0);
    ticks(2);

    // core_done on exactly the MAX_CYC-th RUN cycle of B, then req held high
    req = 1'b1;
    ticks(RST + 1 + 19);
    core_done = 1'b1;
    ticks(1);
    core_done = 1'b0;
    check("tie.done",      32'(done_b),      32'd1);
    check("tie.timed_out", 32'(timed_out_b), 32'd0);
    check("tie.cycles",    32'(cycles_b),    32'd20);
    ticks(5);
    check("hold.busy",       32'(busy_a),       32'd0);
    check("hold.done",       32'(done_a),       32'd1);
    check("hold.core_reset", 32'(core_reset_a), 32'd1);
    req = 1'b0;
    ticks(2);

    // Abort: req seen low on the 5th RUN cycle
    req = 1'b1;
    ticks(RST + 1 + 4);
    req = 1'b0;
    ticks(1);
    check("abort.cycles",     32'(cycles_a),     32'd5);
    check("abort.core_reset", 32'(core_reset_a), 32'd1);
    check("abort.done",       32'(done_a),       32'd0);
    check("abort.busy",       32'(busy_a),       32'd0);
    ticks(3);

    // reset mid-RUN, then a clean run
    req = 1'b1;
    ticks(RST + 1 + 10);
    reset = 1'b1;
    ticks(1);
    check("midrst.cycles",     32'(cycles_a),     32'd0);
    check("midrst.core_reset", 32'(core_reset_a), 32'd1);
    check("midrst.busy",       32'(busy_a),       32'd0);
    reset = 1'b0;
    req = 1'b0;
    ticks(1);
    req = 1'b1;
    ticks(RST + 1 + 9);
    core_done = 1'b1;
    ticks(1);
    core_done = 1'b0;
    check("clean.cycles",    32'(cycles_a),    32'd10);
    check("clean.done",      32'(done_a),      32'd1);
    check("clean.timed_out", 32'(timed_out_a), 32'd0);
    req = 1'b0;
    ticks(2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) req = ~req;
      core_done = ($urandom_range(0, 15) == 0);
      ticks(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run controller that sequences the processor core through a four-phase request/done handshake. It sits between the host or testbench and the core. It holds the core in reset while idle and applies a clean reset pulse on start. It then counts execution cycles, detects program completion or timeout, and freezes the core and captures the final program counter.

## Interface
Parameters:
- D, 12, program counter width (matches core PC).
- RST_CYC, 2, cycles core_reset is held in CLEAR (≥1).
- CW, 16, cycle counter width.
- MAX_CYC, 4095, RUN cycle limit before timeout (1 ≤ MAX_CYC < 2^CW).

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- reset, in, 1, synchronous, active-high; forces the reset state below.
- req, in, 1, run request (level, four-phase).
- core_done, in, 1, core completion flag (core's PC == done address).
- pc, in, D, core program counter.
- core_reset, out, 1, reset to core; 1 whenever core is not in RUN.
- busy, out, 1, high in CLEAR and RUN.
- done, out, 1, run finished; held until req falls.
- timed_out, out, 1, valid with done; 1 if run ended by MAX_CYC.
- cycles, out, CW, RUN cycles of the last/current run.
- end_pc, out, D, pc captured on the RUN→FINISH transition.

## Operation
- States: IDLE, CLEAR, RUN, FINISH. All outputs are registered (driven from state/regs, no comb paths from inputs).
- Reset: state=IDLE, core_reset=1, busy=0, done=0, timed_out=0, cycles=0, end_pc=0.
- IDLE: core_reset=1. If req=1, go to CLEAR; cycles←0, timed_out←0, clear counter loaded with RST_CYC-1.
- CLEAR: core_reset=1, busy=1. Counter decrements. At 0, go to RUN. If req=0, abort to IDLE.
- RUN: core_reset=0, busy=1. cycles increments each RUN cycle, saturating at 2^CW-1. Exit conditions, in priority order:
  - req=0: abort to IDLE. done stays 0; cycles is retained.
  - core_done=1: go to FINISH with timed_out←0.
  - cycles==MAX_CYC-1 (this is the MAX_CYC-th RUN cycle): go to FINISH with timed_out←1.
  - core_done and timeout in the same cycle: core_done wins, timed_out=0.
- On entry to FINISH: end_pc←pc (value on the exiting RUN cycle), done←1.
- FINISH: core_reset=1 (core frozen), done=1. When req=0, go to IDLE and done←0. cycles, end_pc and timed_out hold until the next start.
- A new run requires req low for ≥1 cycle (passing through IDLE). req held high after FINISH never restarts.
- reset asserted in any state returns to IDLE with reset values in the next cycle. No partial state survives.

## Timing
- req sampled high at edge t → busy=1 from t+1. core_reset stays 1 through CLEAR; first core_reset=0 at t+1+RST_CYC.
- core_done sampled at edge e → done=1 and core_reset=1 from e+1. cycles then equals the number of RUN cycles, including cycle e.
- Timeout: done=1 exactly MAX_CYC cycles after RUN entry, with cycles=MAX_CYC.
- req falls at edge f in FINISH → done=0 from f+1.
- Latency req→core running: RST_CYC+1 cycles.

## Structure
- Package run_ctrl_pkg holds the state enum (IDLE, CLEAR, RUN, FINISH) and default parameter constants.
- One sub-module: sat_counter, a CW-bit saturating up-counter with sync clear and enable, used for cycles.
- Keep the CLEAR down-counter and end_pc capture inline.

## Test plan
- Reset: assert reset for 2 cycles → core_reset=1, busy=0, done=0, cycles=0, end_pc=0.
- Normal run, RST_CYC=2: req=1 at t0 → core_reset low at t0+3. core_done pulses after 40 RUN cycles with pc=128 → done=1, timed_out=0, cycles=40, end_pc=128, core_reset=1. Then req=0 → done=0 one cycle later.
- Timeout, MAX_CYC=20, core_done never set → done=1 after 20 RUN cycles, timed_out=1, cycles=20.
- core_done on exactly the 20th RUN cycle (MAX_CYC=20) → timed_out=0, cycles=20.
- Abort: req drops on RUN cycle 5 → IDLE next cycle, core_reset=1, done never asserts, cycles=5. req held high through FINISH → no restart until req low then high.
- reset asserted mid-RUN → next cycle IDLE, cycles=0, core_reset=1; a subsequent req starts a clean run.
